// File: rtl/cle_pkg.sv
// Shared definitions for the CLE188 key sequencer.
// Holds the FSM encoding, the 0x1000 address window and the strobe
// address helper used when loading the address bus.
package cle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_SETUP   = 3'd2,
    ST_STROBE  = 3'd3,
    ST_RECOVER = 3'd4,
    ST_FIN     = 3'd5
  } cle_state_e;

  localparam logic [1:0]  CLE_WIN_BA13_12 = 2'b01;
  localparam logic [13:0] CLE_BASE        = 14'h1000;

  // BA13..BA0 for one read strobe: window bits, nibble on BA7..BA4
  function automatic logic [13:0] cle_ba(input logic [3:0] nib);
    return {CLE_WIN_BA13_12, 4'h0, nib, 4'h0};
  endfunction

endpackage

// File: rtl/cle_key_sequencer_if.sv
// Host/board-side signal bundle of the key sequencer.
// master = sequencer, slave = host control plus board bus and PAL.
// Flow control is start/done/err on the host side, req/gnt on the bus side.
interface cle_key_sequencer_if #(
  parameter int NBITS = 16
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic                     bus_req;
  logic                     bus_gnt;
  logic [$clog2(NBITS)-1:0] addr_idx;
  logic [3:0]               addr_nib;
  logic [13:0]              ba;
  logic                     br_w;
  logic                     sser_n;
  logic                     sdrd;
  logic [NBITS-1:0]         key_data;

  modport master (
    input  start, bus_gnt, addr_nib, sdrd,
    output busy, done, err, bus_req, addr_idx, ba, br_w, sser_n, key_data
  );

  modport slave (
    output start, bus_gnt, addr_nib, sdrd,
    input  busy, done, err, bus_req, addr_idx, ba, br_w, sser_n, key_data
  );
endinterface

// File: rtl/cle_strobe_timer.sv
// Loadable down-counter shared by the grant timeout and the strobe width.
// Latency: zero asserts load_val clocks after the load edge.
// No backpressure: load always wins, counting stops at zero.
module cle_strobe_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // load on request, otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cle_key_sequencer.sv
// Drives the CLE188 PAL read sequence and shifts SDRD into key_data.
// Latency: grant to done = NBITS*(STB_CYC+2)+1 clocks.
// Backpressure: waits up to GNT_TMO clocks for bus_gnt; grant loss aborts with err.
module cle_key_sequencer
  import cle_pkg::*;
#(
  parameter int NBITS   = 16,
  parameter int STB_CYC = 2,
  parameter int GNT_TMO = 64
) (
  input logic               clk,
  input logic               rst,
  cle_key_sequencer_if.master bus
);

  localparam int IW   = $clog2(NBITS);
  localparam int TMAX = (GNT_TMO > STB_CYC) ? GNT_TMO : STB_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(NBITS - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(GNT_TMO - 1);
  localparam logic [TW-1:0] STB_LOAD = TW'(STB_CYC - 1);

  cle_state_e       state;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             req_q;
  logic             sser_q;
  logic             last_q;
  logic [IW-1:0]    idx_q;
  logic [13:0]      ba_q;
  logic [NBITS-1:0] key_q;

  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_zero;
  logic             gnt_lost;

  // timer reload: grant timeout on start, strobe width on entering STROBE
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TMO_LOAD;
    if (state == ST_IDLE && bus.start) begin
      tmr_load = 1'b1;
    end else if (state == ST_SETUP && bus.bus_gnt) begin
      tmr_load = 1'b1;
      tmr_val  = STB_LOAD;
    end
  end

  cle_strobe_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign gnt_lost = (state == ST_SETUP || state == ST_STROBE || state == ST_RECOVER)
                    && !bus.bus_gnt;

  // sequencer FSM with registered bus-side outputs and key capture.
  // addr_idx advances on the capture edge so addr_nib has the whole RECOVER
  // cycle to settle before ba is loaded on SETUP entry; ba therefore only
  // ever changes while sser_n is high. key_data is not cleared on start:
  // bits not yet rewritten keep their previous value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      req_q  <= 1'b0;
      sser_q <= 1'b1;
      last_q <= 1'b0;
      idx_q  <= '0;
      ba_q   <= CLE_BASE;
      key_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (gnt_lost) begin
        state  <= ST_IDLE;
        err_q  <= 1'b1;
        req_q  <= 1'b0;
        busy_q <= 1'b0;
        sser_q <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              state  <= ST_REQ;
              busy_q <= 1'b1;
              req_q  <= 1'b1;
              idx_q  <= '0;
            end
          end
          ST_REQ: begin
            if (bus.bus_gnt) begin
              state <= ST_SETUP;
              ba_q  <= cle_ba(bus.addr_nib);
            end else if (tmr_zero) begin
              state  <= ST_IDLE;
              err_q  <= 1'b1;
              req_q  <= 1'b0;
              busy_q <= 1'b0;
            end
          end
          ST_SETUP: begin
            state  <= ST_STROBE;
            sser_q <= 1'b0;
          end
          ST_STROBE: begin
            if (tmr_zero) begin
              key_q[idx_q] <= bus.sdrd;
              sser_q       <= 1'b1;
              last_q       <= (idx_q == LAST_IDX);
              if (idx_q != LAST_IDX) begin
                idx_q <= idx_q + IW'(1);
              end
              state <= ST_RECOVER;
            end
          end
          ST_RECOVER: begin
            if (last_q) begin
              state  <= ST_FIN;
              done_q <= 1'b1;
              req_q  <= 1'b0;
              busy_q <= 1'b0;
            end else begin
              state <= ST_SETUP;
              ba_q  <= cle_ba(bus.addr_nib);
            end
          end
          ST_FIN: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.bus_req  = req_q;
  assign bus.addr_idx = idx_q;
  assign bus.ba       = ba_q;
  assign bus.br_w     = 1'b1;
  assign bus.sser_n   = sser_q;
  assign bus.key_data = key_q;

endmodule

// File: doc/cle_key_sequencer.md
Name: cle_key_sequencer

Overview:
- Bus-master sequencer that drives the CLE188 key/serial-data PAL through its read sequence and captures the serial bit stream it returns on SDRD.
- Requests the board address bus, then issues NBITS read strobes inside the 0x1000 window (BA13=0, BA12=1). Each strobe carries a caller-supplied address nibble on BA7..BA4.
- Shifts the returned bits into a key word and reports done or error to the host-side control logic.

Parameters:
- NBITS, 16, number of read strobes and key bits captured (2..32).
- STB_CYC, 2, clocks SSER is held low per strobe (1..15).
- GNT_TMO, 64, clocks to wait for bus_gnt before flagging an error (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a key read
- busy  out  1  high from the accepted start until done/err is issued
- done  out  1  one-cycle pulse: key_data valid
- err  out  1  one-cycle pulse: grant timeout or grant lost
- bus_req  out  1  bus request to the arbiter
- bus_gnt  in  1  bus grant from the arbiter
- addr_idx  out  $clog2(NBITS)  index of the current strobe
- addr_nib  in  4  nibble for BA7..BA4, combinational lookup of addr_idx
- ba  out  14  address bus BA13..BA0
- br_w  out  1  read/write line, 1 = read
- sser_n  out  1  PAL select, active low
- sdrd  in  1  serial data bit from the PAL
- key_data  out  NBITS  captured key, bit i = strobe i

Behaviour:
- Reset values:
  - busy=0, done=0, err=0, bus_req=0, sser_n=1, br_w=1.
  - ba=14'h1000, addr_idx=0, key_data=0.
  - FSM in IDLE. A mid-operation reset aborts immediately: bus released, no done/err pulse.
- FSM states: IDLE, REQ, SETUP, STROBE, RECOVER, FIN.
- IDLE:
  - start=1 -> REQ; clear bit counter and timeout counter; busy=1.
  - start is ignored in every other state.
- REQ:
  - bus_req=1.
  - bus_gnt=1 -> SETUP.
  - If the timeout counter reaches GNT_TMO-1 without a grant -> IDLE with err pulse; bus_req drops on the same edge.
- SETUP, 1 clk:
  - ba = {2'b01, 4'h0, addr_nib, 4'h0}; br_w=1; sser_n=1.
  - ba is registered from addr_nib at entry, so addr_nib must be stable when addr_idx changes.
- STROBE, STB_CYC clks:
  - sser_n=0; ba and br_w held.
  - On the last STROBE cycle's clock edge, sdrd is sampled into key_data[addr_idx].
- RECOVER, 1 clk:
  - sser_n=1; ba held.
  - If addr_idx==NBITS-1 -> FIN, else addr_idx+1 and -> SETUP.
- FIN:
  - done pulse for 1 clk; bus_req=0; busy=0; -> IDLE.
  - key_data holds until the next accepted start.
- Grant loss: bus_gnt=0 in SETUP, STROBE or RECOVER takes effect on the next edge.
  - sser_n=1, bus_req=0, err pulse, -> IDLE.
  - key_data is left partially updated, and done is not asserted.
- Bus hold: bus_req stays continuously high from REQ through FIN entry, so there is no per-bit re-arbitration.
- Latency:
  - Grant to done = NBITS*(STB_CYC+2)+1 clks.
  - Defaults: 16*4+1 = 65 clks after grant.
- SSER glitch-free: sser_n is driven from a register, and ba never changes while sser_n=0.

Decomposition:
- Shared package cle_pkg holds:
  - the FSM state enum;
  - localparam CLE_WIN_BA13_12 = 2'b01;
  - localparam CLE_BASE = 14'h1000.
- One sub-module, cle_strobe_timer: a loadable down-counter giving the STROBE duration and the grant timeout (reused in both states).
- Shift/capture and the FSM stay in the top module.

Test Plan:
- Basic read:
  - Stimulus: NBITS=16, STB_CYC=2; grant 3 clks after req; addr_nib=addr_idx; sdrd = bit i of 16'hA5C3 during strobe i.
  - Required: key_data=16'hA5C3; done exactly 65 clks after grant.
  - Required: ba sequence 14'h1000, 1010, ... 10F0; br_w=1 throughout.
- Grant timeout:
  - Stimulus: start with bus_gnt held 0, GNT_TMO=64.
  - Required: err pulse 64 clks after entering REQ; bus_req=0; busy=0; no done.
- Grant lost:
  - Stimulus: drop bus_gnt during STROBE of bit 5.
  - Required: next clk sser_n=1, bus_req=0, err=1; key_data bits 0..4 updated, bits 5..15 unchanged.
- Start while busy:
  - Stimulus: pulse start at bit 3 of a transfer.
  - Required: ignored; a single done pulse; total latency unchanged.
- Async reset mid-strobe:
  - Stimulus: assert rst asynchronously while sser_n=0.
  - Required: sser_n=1 and bus_req=0 before the next clk edge; all outputs at reset values; a new start works normally.
- Strobe width:
  - Stimulus: STB_CYC=1 and STB_CYC=15.
  - Required: sser_n low width exactly 1 and 15 clks respectively; ba stable across each low window.
